// File: rtl/dac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dac_pkg
// Brief    : Shared types and constants for the DAC transmit path.
// Revision : 1.0 - initial release
// ============================================================================
package dac_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RAMP_UP   = 3'd1,
      ST_ON        = 3'd2,
      ST_RAMP_DOWN = 3'd3,
      ST_HOLD      = 3'd4
   } tx_env_state_t;

   localparam int c_in_width = 27;

   // Offset-binary code for zero, used by the downstream rounding stage
   localparam logic [c_in_width-1:0] c_dac_midscale = {1'b1, {(c_in_width-1){1'b0}}};

endpackage
`default_nettype wire

// File: rtl/dac_tx_envelope_env_scaler.sv
`default_nettype none
// ============================================================================
// Module   : env_scaler
// Brief    : Two-stage signed sample x gain multiply followed by >>> ramp_bits.
// Revision : 1.0 - initial release
// ============================================================================
module env_scaler
   import dac_pkg::*;
#(
   parameter int in_width  = c_in_width,
   parameter int ramp_bits = 10
) (
   input  logic                       clk_in,
   input  logic                       reset_in,
   input  logic signed [in_width-1:0] data_in,
   input  logic                       data_valid,
   input  logic        [ramp_bits:0]  gain,
   output logic signed [in_width-1:0] data_out,
   output logic                       data_out_valid
);

   localparam int c_full_w = in_width + ramp_bits + 2;
   localparam int c_prod_w = in_width + ramp_bits + 1;

   logic signed [c_full_w-1:0] w_a;
   logic signed [c_full_w-1:0] w_b;
   logic signed [c_full_w-1:0] w_prod_full;
   logic signed [c_prod_w-1:0] w_shift;
   logic signed [c_prod_w-1:0] r_prod;
   logic                       r_v1;
   logic signed [in_width-1:0] r_data_out;
   logic                       r_v2;

   // Gain is unsigned, so it is zero-extended before the signed multiply
   assign w_a         = {{(ramp_bits+2){data_in[in_width-1]}}, data_in};
   assign w_b         = {{(in_width+1){1'b0}}, gain};
   assign w_prod_full = w_a * w_b;
   assign w_shift     = r_prod >>> ramp_bits;

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_prod     <= '0;
         r_v1       <= 1'b0;
         r_data_out <= '0;
         r_v2       <= 1'b0;
      end else begin
         r_v1 <= data_valid;
         r_v2 <= r_v1;
         if (data_valid) begin
            r_prod <= w_prod_full[c_prod_w-1:0];
         end
         if (r_v1) begin
            r_data_out <= w_shift[in_width-1:0];
         end
      end
   end

   assign data_out       = r_data_out;
   assign data_out_valid = r_v2;

endmodule
`default_nettype wire

// File: rtl/dac_tx_envelope.sv
`default_nettype none
// ============================================================================
// Module   : dac_tx_envelope
// Brief    : PTT amplitude ramp sequencer with post-ramp zero hold.
// Revision : 1.0 - initial release
// ============================================================================
module dac_tx_envelope
   import dac_pkg::*;
#(
   parameter int in_width    = c_in_width,
   parameter int ramp_bits   = 10,
   parameter int hold_cycles = 4096
) (
   input  logic                       clk_in,
   input  logic                       reset_in,
   input  logic                       tx_req,
   input  logic signed [in_width-1:0] DATA_IN,
   input  logic                       DATA_VALID,
   output logic signed [in_width-1:0] DATA_OUT,
   output logic                       DATA_OUT_VALID,
   output logic                       tx_active,
   output logic                       ramp_busy
);

   localparam int                  c_gw        = ramp_bits + 1;
   localparam logic [c_gw-1:0]     c_g_full    = {1'b1, {ramp_bits{1'b0}}};
   localparam int                  c_hold_w    = (hold_cycles > 1) ? $clog2(hold_cycles) : 1;
   localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(hold_cycles - 1);

   tx_env_state_t       r_state;
   tx_env_state_t       w_base;
   tx_env_state_t       w_next;
   logic [c_gw-1:0]     r_g;
   logic [c_gw-1:0]     w_g_next;
   logic [c_hold_w-1:0] r_hold_cnt;
   logic [c_hold_w-1:0] w_hold_next;
   logic                r_tx_active;
   logic                r_ramp_busy;

   always_comb begin
      w_base      = r_state;
      w_next      = r_state;
      w_g_next    = r_g;
      w_hold_next = '0;

      case (r_state)
         ST_IDLE:      if (tx_req)  w_base = ST_RAMP_UP;
         ST_RAMP_UP:   if (!tx_req) w_base = ST_RAMP_DOWN;
         ST_ON:        if (!tx_req) w_base = ST_RAMP_DOWN;
         ST_RAMP_DOWN: if (tx_req)  w_base = ST_RAMP_UP;
         ST_HOLD: begin
            if (tx_req)                       w_base = ST_RAMP_UP;
            else if (r_hold_cnt == c_hold_last) w_base = ST_IDLE;
            else                              w_hold_next = r_hold_cnt + c_hold_w'(1);
         end
         default:                   w_base = ST_IDLE;
      endcase

      // The gain step follows the direction of the state being entered
      case (w_base)
         ST_RAMP_UP:   if (DATA_VALID && (r_g != c_g_full)) w_g_next = r_g + c_gw'(1);
         ST_RAMP_DOWN: if (DATA_VALID && (r_g != '0))       w_g_next = r_g - c_gw'(1);
         ST_ON:        w_g_next = c_g_full;
         default:      w_g_next = '0;
      endcase

      w_next = w_base;
      if ((w_base == ST_RAMP_UP) && (w_g_next == c_g_full)) w_next = ST_ON;
      if ((w_base == ST_RAMP_DOWN) && (w_g_next == '0))     w_next = ST_HOLD;
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_state     <= ST_IDLE;
         r_g         <= '0;
         r_hold_cnt  <= '0;
         r_tx_active <= 1'b0;
         r_ramp_busy <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_g         <= w_g_next;
         r_hold_cnt  <= w_hold_next;
         r_tx_active <= (w_next != ST_IDLE);
         r_ramp_busy <= (w_next == ST_RAMP_UP) || (w_next == ST_RAMP_DOWN);
      end
   end

   env_scaler #(
      .in_width  (in_width),
      .ramp_bits (ramp_bits)
   ) u_env_scaler (
      .clk_in         (clk_in),
      .reset_in       (reset_in),
      .data_in        (DATA_IN),
      .data_valid     (DATA_VALID),
      .gain           (r_g),
      .data_out       (DATA_OUT),
      .data_out_valid (DATA_OUT_VALID)
   );

   assign tx_active = r_tx_active;
   assign ramp_busy = r_ramp_busy;

endmodule
`default_nettype wire

// File: tb/tb_dac_tx_envelope.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_tx_envelope
// Brief    : Randomized scoreboard bench for dac_tx_envelope (G=16, hold=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_tx_envelope;

   localparam int W  = 27;
   localparam int RB = 4;
   localparam int G  = 16;
   localparam int HC = 8;

   logic                clk_in = 1'b0;
   logic                reset_in;
   logic                tx_req;
   logic signed [W-1:0] data_in;
   logic                data_valid;
   logic signed [W-1:0] data_out;
   logic                data_out_valid;
   logic                tx_active;
   logic                ramp_busy;

   dac_tx_envelope #(
      .in_width    (W),
      .ramp_bits   (RB),
      .hold_cycles (HC)
   ) dut (
      .clk_in         (clk_in),
      .reset_in       (reset_in),
      .tx_req         (tx_req),
      .DATA_IN        (data_in),
      .DATA_VALID     (data_valid),
      .DATA_OUT       (data_out),
      .DATA_OUT_VALID (data_out_valid),
      .tx_active      (tx_active),
      .ramp_busy      (ramp_busy)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   typedef struct {
      int data;
      int due;
   } exp_t;

   exp_t sb[$];
   int   n_err    = 0;
   int   n_chk    = 0;
   int   last_out = 0;
   bit   mon_en   = 1'b0;

   // Reference model: gain value, keyed flag, hold progress (-1 = not holding)
   int m_g        = 0;
   int m_hold     = -1;
   bit m_act      = 1'b0;
   bit m_prev_req = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic int scale(input int d, input int g);
      int p, q;
      p = d * g;
      q = p / G;
      if ((p < 0) && ((p % G) != 0)) q = q - 1;
      return q;
   endfunction

   function automatic bit m_busy();
      return m_act && (m_hold < 0) && !((m_g == G) && m_prev_req);
   endfunction

   task automatic model_reset();
      m_g        = 0;
      m_hold     = -1;
      m_act      = 1'b0;
      m_prev_req = 1'b0;
   endtask

   task automatic step(input bit req, input bit v, input int din);
      @(negedge clk_in);
      #1;
      check("tx_active", int'(tx_active), int'(m_act));
      check("ramp_busy", int'(ramp_busy), int'(m_busy()));
      reset_in   = 1'b0;
      tx_req     = req;
      data_valid = v;
      data_in    = din[W-1:0];
      if (v) sb.push_back('{scale(din, m_g), cyc + 2});
      if (req) begin
         m_hold = -1;
         m_act  = 1'b1;
         if (v && (m_g < G)) m_g++;
      end else if (!m_act) begin
         m_g = 0;
      end else if (m_hold >= 0) begin
         m_hold++;
         if (m_hold == HC) begin
            m_act  = 1'b0;
            m_hold = -1;
         end
      end else begin
         if (v && (m_g > 0)) m_g--;
         if (m_g == 0) m_hold = 0;
      end
      m_prev_req = req;
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      #1;
      reset_in   = 1'b1;
      tx_req     = 1'b0;
      data_valid = 1'b0;
      sb.delete();
      last_out = 0;
      model_reset();
   endtask

   always @(negedge clk_in) begin
      exp_t e;
      if (mon_en) begin
         if ((sb.size() > 0) && (sb[0].due < cyc)) begin
            check("out_valid_missing", 0, 1);
            void'(sb.pop_front());
         end
         if (data_out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               check("out_valid_unexpected", 1, 0);
            end else begin
               e = sb.pop_front();
               check("out_cycle", cyc, e.due);
               check("data_out", int'(data_out), e.data);
               last_out = e.data;
            end
         end else begin
            check("data_out_hold", int'(data_out), last_out);
         end
      end
   end

   initial begin
      logic signed [W-1:0] r;
      bit                  req;
      reset_in   = 1'b1;
      tx_req     = 1'b0;
      data_valid = 1'b0;
      data_in    = '0;
      repeat (3) @(negedge clk_in);
      model_reset();
      mon_en = 1'b1;

      // Idle: output pinned to zero whatever the input
      for (int i = 0; i < 4; i++) begin
         r = W'($urandom);
         step(1'b0, 1'b1, int'(r));
      end

      // Key-up with a constant 1000, then random samples in ON
      for (int i = 0; i < 22; i++) step(1'b1, 1'b1, 1000);
      for (int i = 0; i < 8; i++) begin
         r = W'($urandom);
         step(1'b1, 1'b1, int'(r));
      end

      // Reset while keyed
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1000);
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1000);

      // Negative ramp aborted at g=5, re-keyed at hold count 3
      for (int i = 0; i < 40 && m_g != 5; i++) step(1'b1, 1'b1, -1000);
      check("abort_gain_reached", m_g, 5);
      for (int i = 0; i < 40 && m_hold != 3; i++) step(1'b0, 1'b1, -1000);
      check("hold_count_reached", m_hold, 3);
      for (int i = 0; i < 22; i++) step(1'b1, 1'b1, -1000);
      for (int i = 0; i < 30; i++) step(1'b0, 1'b1, -1000);

      // Sparse strobes, one every fourth clock
      for (int i = 0; i < 80; i++) begin
         r = W'($urandom);
         step(1'b1, (i % 4) == 0, int'(r));
      end
      for (int i = 0; i < 100; i++) begin
         r = W'($urandom);
         step(1'b0, (i % 4) == 0, int'(r));
      end

      // Random PTT activity with random strobes
      req = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(39, 0) == 0) req = ~req;
         r = W'($urandom);
         step(req, $urandom_range(1, 0) == 1, int'(r));
      end

      for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 0);
      check("scoreboard_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
